// File: rtl/vn_packer.sv
// Von Neumann debiaser and word packer for a ring-oscillator TRNG front end.
// Optional repetition count health test is built when TRNG_RCT_EN is defined.
module vn_packer #(
    parameter int WIDTH      = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             raw_bit,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             health_fail
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        EMPTY      = 1'b0,
        HAVE_FIRST = 1'b1
    } pair_state_e;

    pair_state_e      state_q, state_d;
    logic             first_q, first_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             hf_q;

    logic             emit;
    logic             xfer;
    logic [WIDTH-1:0] full_word;

`ifdef TRNG_RCT_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    logic [RW-1:0] run_q, run_d;
    logic          last_q, last_d;
    logic          hf_d;

    // Run length of identical sampled bits; saturates and holds while disabled.
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        hf_d   = hf_q;
        if (enable) begin
            last_d = raw_bit;
            if (run_q == '0 || raw_bit != last_q) begin
                run_d = RW'(1);
            end else if (run_q != RW'(RCT_CUTOFF)) begin
                run_d = run_q + RW'(1);
            end
            if (run_d == RW'(RCT_CUTOFF)) begin
                hf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q  <= '0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end
`else
    assign hf_q = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        emit      = 1'b0;
        xfer      = valid_q & data_ready;

        if (xfer) begin
            valid_d = 1'b0;
        end

        // A dropped enable discards a half pair but keeps the partial word.
        if (!enable) begin
            state_d = EMPTY;
        end else if (state_q == EMPTY) begin
            state_d = HAVE_FIRST;
            first_d = raw_bit;
        end else begin
            state_d = EMPTY;
            emit    = (first_q != raw_bit);
        end

        full_word = {word_q[WIDTH-2:0], first_q};

        if (emit) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                word_d = '0;
                // After a health failure completed words are silently discarded.
                if (!hf_q) begin
                    if (!valid_q || xfer) begin
                        dout_d  = full_word;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end else begin
                cnt_d  = cnt_q + CW'(1);
                word_d = full_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            first_q <= 1'b0;
            cnt_q   <= '0;
            word_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign overrun     = ovr_q;
    assign health_fail = hf_q;

endmodule

// File: tb/tb_vn_packer.sv
// Scoreboard bench for vn_packer: queue-based reference model, decoupled monitor.
// Exercises the health test too when TRNG_RCT_EN is defined.
module tb_vn_packer;

    localparam int W   = 8;
    localparam int CUT = 32;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         raw_bit;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         overrun;
    logic         health_fail;

    int total = 0;
    int bad   = 0;
    logic rdy_v = 1'b1;

    // reference model state
    bit       half_q[$];
    bit       bits_q[$];
    bit [W-1:0] exp_q[$];
    bit       m_full;
    bit [W-1:0] m_word;
    bit       m_ovr;
    bit       m_hf;
    int       m_run;
    bit       m_last;

    // monitor observations
    logic [W-1:0] last_word;
    int           nxfer = 0;

    vn_packer #(.WIDTH(W), .RCT_CUTOFF(CUT)) dut (
        .clock      (clk),
        .reset      (reset),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .health_fail(health_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: pairs, emitted bits and words as plain queues.
    always @(posedge clk) begin
        bit f;
        bit hf_before;
        bit [W-1:0] w;
        if (reset) begin
            half_q.delete();
            bits_q.delete();
            exp_q.delete();
            m_full = 0; m_word = '0; m_ovr = 0; m_hf = 0; m_run = 0; m_last = 0;
        end else begin
            hf_before = m_hf;
            if (m_full && data_ready) m_full = 0;
            if (enable) begin
`ifdef TRNG_RCT_EN
                if (m_run == 0 || raw_bit != m_last) m_run = 1;
                else if (m_run < CUT) m_run = m_run + 1;
                m_last = raw_bit;
                if (m_run >= CUT) m_hf = 1;
`endif
                if (half_q.size() == 0) begin
                    half_q.push_back(raw_bit);
                end else begin
                    f = half_q.pop_front();
                    if (f != raw_bit) bits_q.push_back(f);
                end
                if (bits_q.size() == W) begin
                    w = '0;
                    foreach (bits_q[i]) w = (w << 1) | W'(bits_q[i]);
                    bits_q.delete();
                    if (!hf_before) begin
                        if (!m_full) begin
                            m_full = 1; m_word = w; exp_q.push_back(w);
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end else begin
                half_q.delete();
            end
        end
    end

    // Monitor: mid-cycle, compares flags and pops on each handshake.
    always @(negedge clk) begin
        bit [W-1:0] e;
        chk("valid", 32'(data_valid), 32'(m_full));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("health", 32'(health_fail), 32'(m_hf));
        if (m_full) chk("dout_hold", 32'(data_out), 32'(m_word));
        if (data_valid === 1'b1 && data_ready === 1'b1 && reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL word_unexpected: got %0h expected none", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("word", 32'(data_out), 32'(e));
            end
            last_word = data_out;
            nxfer++;
        end
    end

    task automatic cyc(input logic r, input logic e, input logic b);
        reset = r; enable = e; raw_bit = b; data_ready = rdy_v;
        @(posedge clk);
        #2;
    endtask

    task automatic pair(input logic a, input logic b);
        cyc(0, 1, a);
        cyc(0, 1, b);
    endtask

    task automatic emit_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            if (w[i]) pair(1, 0); else pair(0, 1);
        end
    endtask

    initial begin
        int n0;
        reset = 1; enable = 0; raw_bit = 0; data_ready = 1;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_hf", 32'(health_fail), 0);

        // 10,01,10,10,01,01,10,01 -> 8'b10110010, valid for exactly one cycle
        rdy_v = 1;
        n0 = nxfer;
        pair(1,0); pair(0,1); pair(1,0); pair(1,0);
        pair(0,1); pair(0,1); pair(1,0); pair(0,1);
        chk("p28_valid_on", 32'(data_valid), 1);
        chk("p28_dout", 32'(data_out), 32'h000000B2);
        cyc(0, 0, 0);
        chk("p28_valid_off", 32'(data_valid), 0);
        chk("p28_last", 32'(last_word), 32'h000000B2);
        chk("p28_count", 32'(nxfer - n0), 1);

        // equal pairs emit nothing, then a word of ones
        n0 = nxfer;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) pair(0, 0); else pair(1, 1);
        end
        chk("p29_none", 32'(nxfer - n0), 0);
        chk("p29_valid", 32'(data_valid), 0);
        emit_word(8'hFF);
        cyc(0, 0, 0);
        chk("p29_last", 32'(last_word), 32'h000000FF);

        // back-pressure: first word held, second dropped
        rdy_v = 0;
        emit_word(8'h3C);
        emit_word(8'hC3);
        chk("p30_valid", 32'(data_valid), 1);
        chk("p30_hold", 32'(data_out), 32'h0000003C);
        chk("p30_ovr", 32'(overrun), 1);
        rdy_v = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("p30_drain", 32'(data_valid), 0);
        chk("p30_last", 32'(last_word), 32'h0000003C);

        // half pair discarded across an enable gap
        pair(1,0); pair(1,0); pair(1,0);
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        pair(0,1);
        pair(1,0); pair(1,0); pair(1,0); pair(1,0);
        cyc(0, 0, 0);
        chk("p31_last", 32'(last_word), 32'h000000EF);

        // mid-word reset
        pair(1,0); pair(1,0); pair(0,1); pair(1,0); pair(1,0);
        cyc(1, 1, 1);
        chk("p33_dout", 32'(data_out), 0);
        chk("p33_valid", 32'(data_valid), 0);
        chk("p33_ovr", 32'(overrun), 0);
        emit_word(8'hA5);
        cyc(0, 0, 0);
        chk("p33_last", 32'(last_word), 32'h000000A5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy_v = ($urandom_range(0, 9) < 7);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), 1'($urandom));
        end
        rdy_v = 1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(data_valid), 0);

`ifdef TRNG_RCT_EN
        cyc(1, 0, 0);
        for (int i = 0; i < CUT - 1; i++) cyc(0, 1, 1);
        chk("rct_before", 32'(health_fail), 0);
        cyc(0, 1, 1);
        chk("rct_trip", 32'(health_fail), 1);
        n0 = nxfer;
        emit_word(8'h5A);
        cyc(0, 0, 0);
        chk("rct_noword", 32'(nxfer - n0), 0);
        chk("rct_novalid", 32'(data_valid), 0);
        cyc(1, 0, 0);
        chk("rct_reset", 32'(health_fail), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vn_packer.md
VN_PACKER -- requirements
Module: vn_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per output word (2..32).
REQ-002 SHALL have parameter RCT_CUTOFF, default 32: identical consecutive raw bits that trip the health test (2..255).
REQ-003 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1: sampling enable, shared with the upstream ring-oscillator combiner.
REQ-006 SHALL have port raw_bit  input  1: registered XOR-combined raw entropy bit from the upstream combiner, one per clock.
REQ-007 SHALL have port data_out  output  WIDTH: packed debiased word.
REQ-008 SHALL have port data_valid  output  1: data_out holds an unconsumed word.
REQ-009 SHALL have port data_ready  input  1: consumer accepts the word.
REQ-010 SHALL have port overrun  output  1: sticky; a completed word was dropped.
REQ-011 SHALL have port health_fail  output  1: sticky repetition-test failure (see Configuration).

Function
REQ-012 SHALL sample raw_bit on every rising edge with enable=1; no samples when enable=0.
REQ-013 Pair FSM SHALL have states EMPTY and HAVE_FIRST: EMPTY+sample -> store bit, go HAVE_FIRST; HAVE_FIRST+sample -> evaluate pair, go EMPTY.
REQ-014 Pair evaluation SHALL be von Neumann: (first,second)=(1,0) emits 1, (0,1) emits 0, (0,0)/(1,1) emit nothing.
REQ-015 enable=0 SHALL force the FSM to EMPTY (half pair discarded) while keeping partial word bits and output register.
REQ-016 Emitted bits SHALL shift into the word at the LSB (first emitted bit ends in data_out[WIDTH-1]); bit counter 0..WIDTH-1, wraps to 0 on completion.
REQ-017 On the edge accepting the WIDTH-th bit, the completed word SHALL load into data_out and data_valid SHALL rise on that edge (zero extra latency), if the output register is empty or transfers on that edge.
REQ-018 A transfer SHALL occur on any edge with data_valid=1 and data_ready=1; data_out SHALL stay stable while data_valid=1 and data_ready=0.
REQ-019 Transfer and completion on the same edge SHALL load the new word and keep data_valid=1.
REQ-020 Completion while output full and no transfer SHALL drop the new word, set overrun, and restart packing from counter 0.
REQ-021 data_valid SHALL never depend combinationally on data_ready.

Reset
REQ-022 reset=1 at an edge SHALL set FSM EMPTY, counter 0, partial word 0, data_out 0, data_valid 0, overrun 0, health_fail 0, run counter 0.
REQ-023 reset SHALL take priority over enable, sampling and handshake on the same edge; mid-word reset discards partial bits.

Configuration
REQ-024 Macro TRNG_RCT_EN SHALL control the repetition count test.
REQ-025 With TRNG_RCT_EN defined: run counter counts consecutive identical sampled raw bits (1 on a change); reaching RCT_CUTOFF SHALL set health_fail, after which no further words load and data_valid falls after the pending word transfers.
REQ-026 With TRNG_RCT_EN defined: run counter SHALL saturate at RCT_CUTOFF and hold across enable=0.
REQ-027 Without TRNG_RCT_EN: no run counter is built and health_fail SHALL be tied 0.

Verification
REQ-028 WIDTH=8, data_ready=1, raw pairs 10,01,10,10,01,01,10,01 -> one word 8'b10110010, data_valid high exactly one cycle on 16th sample edge.
REQ-029 raw stream 00,11 repeated 20 pairs then 10 x8 -> no words during 00/11; then 8'hFF.
REQ-030 data_ready=0 for two complete words -> first held stable, second dropped, overrun=1; data_ready=1 -> first transfers, data_valid=0.
REQ-031 enable dropped after first bit of a pair, raw toggling -> half pair discarded, word bit count unchanged, next pair evaluated fresh.
REQ-032 TRNG_RCT_EN, RCT_CUTOFF=32, raw_bit=1 held 32 enabled cycles -> health_fail=1 on 32nd sample edge, no further data_valid; reset -> health_fail=0.
REQ-033 reset asserted after 5 emitted bits -> all outputs 0 next edge; 8 new emitted bits form a full word from counter 0.
